// File: rtl/shader_sequencer_pkg.sv
// Shared definitions for the shader sequencer: shader ids, default program count,
// FSM state encoding and the fade weight ceiling.
package shader_sequencer_pkg;

  localparam logic [3:0] SHADER_HGRAD   = 4'd0;
  localparam logic [3:0] SHADER_VGRAD   = 4'd1;
  localparam logic [3:0] SHADER_RADIAL  = 4'd2;
  localparam logic [3:0] SHADER_CHECKER = 4'd3;
  localparam logic [3:0] SHADER_SINE    = 4'd4;
  localparam logic [3:0] SHADER_SPIRAL  = 4'd5;

  localparam int NUM_SHADERS_DEF = 6;

  localparam logic [3:0] BLEND_MAX = 4'd15;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_FADE = 1'b1
  } seq_state_t;

  // Wraps the last program back to program 0.
  function automatic logic [3:0] next_shader(input logic [3:0] cur, input int num);
    return (int'(cur) >= num - 1) ? 4'd0 : cur + 4'd1;
  endfunction

endpackage

// File: rtl/shader_sequencer_btn_debounce.sv
// Raw active-low button -> 2-flop synchronizer -> debounced level -> 1-cycle press pulse.
// Pulse fires DEBOUNCE_CYCLES+2 cycles after a clean falling edge; releases are silent.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synchronized samples that disagree with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/shader_sequencer.sv
// Frame-synchronous shader program sequencer with 16-frame cross-fade and two debounced buttons.
// All outputs are registered and change only on the cycle after frame_start (auto_mode: after a mode press).
module shader_sequencer
  import shader_sequencer_pkg::*;
#(
  parameter int NUM_SHADERS       = NUM_SHADERS_DEF,
  parameter int FRAMES_PER_SHADER = 30,
  parameter int DEBOUNCE_CYCLES   = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next_n,
  input  logic       btn_mode_n,
  input  logic       frame_start,
  output logic [3:0] shader_select,
  output logic [3:0] shader_next,
  output logic [3:0] blend,
  output logic       auto_mode,
  output logic       fading
);

  localparam int DW = $clog2(FRAMES_PER_SHADER + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(FRAMES_PER_SHADER - 1);

  logic          next_press;
  logic          mode_press;
  seq_state_t    state;
  logic [DW-1:0] dwell;
  logic          pending;

  logic          auto_nxt;
  logic [DW-1:0] dwell_base;
  logic          pend_nxt;
  logic          fade_go;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_next_n),
    .press (next_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_mode_n),
    .press (mode_press)
  );

  // A coincident mode press is applied before the dwell test, so the test sees the cleared dwell.
  always_comb begin
    auto_nxt   = auto_mode ^ mode_press;
    dwell_base = mode_press ? '0 : dwell;
    pend_nxt   = pending | next_press;
    fade_go    = pend_nxt | (auto_nxt & (dwell_base == DWELL_LAST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_HOLD;
      shader_select <= 4'd0;
      shader_next   <= 4'd0;
      blend         <= 4'd0;
      fading        <= 1'b0;
      auto_mode     <= 1'b1;
      dwell         <= '0;
      pending       <= 1'b0;
    end else begin
      auto_mode <= auto_nxt;
      pending   <= pend_nxt;
      dwell     <= dwell_base;
      case (state)
        ST_HOLD: begin
          if (frame_start) begin
            if (fade_go) begin
              state       <= ST_FADE;
              shader_next <= next_shader(shader_select, NUM_SHADERS);
              blend       <= 4'd1;
              fading      <= 1'b1;
              pending     <= 1'b0;
              dwell       <= '0;
            end else if (auto_nxt && (dwell_base != DWELL_LAST)) begin
              dwell <= dwell_base + 1'b1;
            end
          end
        end
        ST_FADE: begin
          if (frame_start) begin
            if (blend == BLEND_MAX) begin
              state         <= ST_HOLD;
              shader_select <= shader_next;
              blend         <= 4'd0;
              fading        <= 1'b0;
              dwell         <= '0;
            end else begin
              blend <= blend + 4'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shader_sequencer.sv
// Directed bench for shader_sequencer: auto cycling, manual advance, pending depth,
// button bounce rejection and asynchronous reset mid-fade.
module tb_shader_sequencer;

  logic       clk;
  logic       rst_n;
  logic       btn_next_n;
  logic       btn_mode_n;
  logic       frame_start;
  logic [3:0] shader_select;
  logic [3:0] shader_next;
  logic [3:0] blend;
  logic       auto_mode;
  logic       fading;

  int checks   = 0;
  int failures = 0;
  int mode_presses = 0;

  shader_sequencer #(
    .NUM_SHADERS       (6),
    .FRAMES_PER_SHADER (3),
    .DEBOUNCE_CYCLES   (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_next_n    (btn_next_n),
    .btn_mode_n    (btn_mode_n),
    .frame_start   (frame_start),
    .shader_select (shader_select),
    .shader_next   (shader_next),
    .blend         (blend),
    .auto_mode     (auto_mode),
    .fading        (fading)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (dut.u_mode_db.press) mode_presses++;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One frame: a single-cycle frame_start pulse, then idle; outputs are sampled on falling edges.
  task automatic frame_pulse();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    repeat (98) @(negedge clk);
  endtask

  task automatic press_next();
    @(negedge clk) btn_next_n = 1'b0;
    repeat (12) @(negedge clk);
    btn_next_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic press_mode();
    @(negedge clk) btn_mode_n = 1'b0;
    repeat (12) @(negedge clk);
    btn_mode_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // holds idle frames in HOLD, then a full 16-frame fade from -> to.
  task automatic run_transition(input int from, input int to, input int holds);
    for (int h = 0; h < holds; h++) begin
      frame_pulse();
      check_val("hold_fading", fading, 0);
      check_val("hold_select", shader_select, from);
      check_val("hold_next_eq_select", shader_next, from);
    end
    frame_pulse();
    check_val("fade_start_fading", fading, 1);
    check_val("fade_start_next", shader_next, to);
    check_val("fade_start_select", shader_select, from);
    check_val("fade_start_blend", blend, 1);
    for (int b = 2; b <= 15; b++) begin
      frame_pulse();
      check_val("fade_blend_step", blend, b);
    end
    frame_pulse();
    check_val("fade_end_select", shader_select, to);
    check_val("fade_end_next", shader_next, to);
    check_val("fade_end_blend", blend, 0);
    check_val("fade_end_fading", fading, 0);
  endtask

  initial begin
    int lat;
    int presses_before;

    rst_n       = 1'b0;
    btn_next_n  = 1'b1;
    btn_mode_n  = 1'b1;
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_select", shader_select, 0);
    check_val("rst_next", shader_next, 0);
    check_val("rst_blend", blend, 0);
    check_val("rst_fading", fading, 0);
    check_val("rst_auto", auto_mode, 1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Auto mode from reset: fade on the 3rd frame_start, then cycle through all six and wrap.
    run_transition(0, 1, 2);
    for (int s = 1; s <= 5; s++) run_transition(s, (s + 1) % 6, 2);
    check_val("wrap_select", shader_select, 0);

    // Manual mode: no transitions for 10 frames, then a next press advances at the next frame.
    press_mode();
    check_val("manual_auto", auto_mode, 0);
    for (int f = 0; f < 10; f++) begin
      frame_pulse();
      check_val("manual_idle_fading", fading, 0);
      check_val("manual_idle_select", shader_select, 0);
    end
    press_next();
    run_transition(0, 1, 0);

    // Three presses during a fade: one queued transition, the rest dropped.
    press_next();
    frame_pulse();
    check_val("p4_start_fading", fading, 1);
    check_val("p4_start_next", shader_next, 2);
    press_next();
    press_next();
    press_next();
    for (int b = 2; b <= 15; b++) begin
      frame_pulse();
      check_val("p4_blend_step", blend, b);
    end
    frame_pulse();
    check_val("p4_end_select", shader_select, 2);
    check_val("p4_end_fading", fading, 0);
    run_transition(2, 3, 0);
    for (int f = 0; f < 2; f++) begin
      frame_pulse();
      check_val("p4_dropped_fading", fading, 0);
      check_val("p4_dropped_select", shader_select, 3);
    end

    // Bouncing mode button: three 2-cycle glitches, then held low.
    presses_before = mode_presses;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk) btn_mode_n = 1'b0;
      repeat (2) @(negedge clk);
      btn_mode_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    btn_mode_n = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (dut.u_mode_db.press && lat == 0) lat = i;
    end
    check_val("bounce_latency_6pm1", (lat >= 5 && lat <= 7), 1);
    repeat (10) @(negedge clk);
    btn_mode_n = 1'b1;
    repeat (20) @(negedge clk);
    check_val("bounce_pulse_count", mode_presses - presses_before, 1);
    check_val("bounce_auto", auto_mode, 1);

    // Reset in the middle of a fade, then normal dwell resumes.
    frame_pulse();
    frame_pulse();
    frame_pulse();
    check_val("r6_start_fading", fading, 1);
    check_val("r6_start_next", shader_next, 4);
    repeat (7) frame_pulse();
    check_val("r6_blend_before_reset", blend, 8);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("r6_rst_select", shader_select, 0);
    check_val("r6_rst_next", shader_next, 0);
    check_val("r6_rst_blend", blend, 0);
    check_val("r6_rst_fading", fading, 0);
    check_val("r6_rst_auto", auto_mode, 1);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    run_transition(0, 1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
